interval_meter: RTL

- Measures the time between two consecutive rising edges of an external trigger line. This is the receiving end of the periodic trigger that our timer blocks generate.
- The result is reported as whole microseconds plus residual clock cycles, using the same req/busy/ack app handshake the timer uses.
- Sits between external trigger inputs (or timer outputs) and control logic that needs period, latency or pulse-spacing figures.

---
 rtl/interval_meter.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/interval_meter.sv
// ----------------------------------------------------------------------------
// interval_meter
//
// Measures the time between two consecutive rising edges of an external
// trigger line. The result is whole microseconds plus residual clocks and
// is returned through a req/busy/ack handshake.
//
// Ports:
//   I_Clk         system clock
//   I_rst         synchronous, active-high reset
//   I_trig        asynchronous trigger line (rising edges are measured)
//   I_app_req     start request, only looked at while idle
//   O_app_busy    high while armed or measuring (registered, one cycle late)
//   O_app_ack     one-cycle pulse, result outputs valid in the same cycle
//   O_app_us      measured whole microseconds
//   O_app_clk     residual clocks, 0..CLK_FRE-1
//   O_app_timeout qualifies O_app_ack: 1 = measurement gave up
//
// Parameters:
//   CLK_FRE    clock frequency in MHz (clocks per microsecond), 1..256
//   TIMEOUT_US give-up limit in microseconds for each phase, >= 1
//   LOOP       1 = back-to-back period measurement, 0 = single shot
// ----------------------------------------------------------------------------
module interval_meter #(
    parameter int          CLK_FRE    = 50,
    parameter logic [31:0] TIMEOUT_US = 32'd1000,
    parameter logic        LOOP       = 1'b0
) (
    input  logic        I_Clk,
    input  logic        I_rst,
    input  logic        I_trig,
    input  logic        I_app_req,
    output logic        O_app_busy,
    output logic        O_app_ack,
    output logic [31:0] O_app_us,
    output logic [7:0]  O_app_clk,
    output logic        O_app_timeout
);

    // Last value of the residual-clock counter before it wraps.
    localparam logic [7:0]  CLK_MAX    = 8'(CLK_FRE - 1);
    // us_cnt value in the final microsecond before the timeout limit.
    localparam logic [31:0] US_LAST    = TIMEOUT_US - 32'd1;
    // Counter value one clock after an interval starts. With CLK_FRE=1 a
    // single clock is already a whole microsecond.
    localparam logic [7:0]  CLK_START  = (CLK_FRE == 1) ? 8'd0  : 8'd1;
    localparam logic [31:0] US_START   = (CLK_FRE == 1) ? 32'd1 : 32'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_MEAS = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state, state_nx;

    logic        trig_s1, trig_s2, trig_s3;
    logic        trig_rise;

    logic [31:0] us_cnt;
    logic [7:0]  clk_cnt;
    logic        at_limit;

    logic        cnt_clr;
    logic        cnt_start;
    logic        finish;
    logic        finish_to;

    // ------------------------------------------------------------------
    // Trigger synchroniser and registered rising-edge detector. An edge on
    // I_trig shows up on trig_rise three clocks later, the same for every
    // edge, so it cancels out of the measured difference.
    // ------------------------------------------------------------------
    always_ff @(posedge I_Clk) begin
        if (I_rst) begin
            trig_s1   <= 1'b0;
            trig_s2   <= 1'b0;
            trig_s3   <= 1'b0;
            trig_rise <= 1'b0;
        end else begin
            trig_s1   <= I_trig;
            trig_s2   <= trig_s1;
            trig_s3   <= trig_s2;
            trig_rise <= trig_s2 & ~trig_s3;
        end
    end

    // ------------------------------------------------------------------
    // Interval counter. Restarted on the clock that ends the start-edge
    // cycle, so in the cycle of the next edge it holds exactly t1 - t0.
    // In S_ARM it counts from zero at S_ARM entry to time the wait for the
    // first edge.
    // ------------------------------------------------------------------
    always_ff @(posedge I_Clk) begin
        if (I_rst || cnt_clr) begin
            us_cnt  <= 32'd0;
            clk_cnt <= 8'd0;
        end else if (cnt_start) begin
            us_cnt  <= US_START;
            clk_cnt <= CLK_START;
        end else if (clk_cnt == CLK_MAX) begin
            us_cnt  <= us_cnt + 32'd1;
            clk_cnt <= 8'd0;
        end else begin
            clk_cnt <= clk_cnt + 8'd1;
        end
    end

    // True in the cycle whose closing clock would bring the count to
    // TIMEOUT_US*CLK_FRE. Deciding here puts the timeout ack exactly
    // TIMEOUT_US*CLK_FRE clocks after the phase started.
    assign at_limit = (us_cnt == US_LAST) && (clk_cnt == CLK_MAX);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge I_Clk) begin
        if (I_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and datapath controls. An edge always takes priority
    // over a timeout landing in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        state_nx  = state;
        cnt_clr   = 1'b0;
        cnt_start = 1'b0;
        finish    = 1'b0;
        finish_to = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_clr = 1'b1;
                if (I_app_req) begin
                    state_nx = S_ARM;
                end
            end
            S_ARM: begin
                if (trig_rise) begin
                    cnt_start = 1'b1;
                    state_nx  = S_MEAS;
                end else if (at_limit) begin
                    finish    = 1'b1;
                    finish_to = 1'b1;
                    state_nx  = S_DONE;
                end
            end
            S_MEAS: begin
                if (trig_rise) begin
                    // The terminating edge is also the start of the next
                    // interval in loop mode; restarting here leaves no gap.
                    finish    = 1'b1;
                    cnt_start = 1'b1;
                    state_nx  = S_DONE;
                end else if (at_limit) begin
                    finish    = 1'b1;
                    finish_to = 1'b1;
                    state_nx  = S_DONE;
                end
            end
            S_DONE: begin
                // O_app_timeout already holds this result's flag here.
                if (LOOP && !O_app_timeout) begin
                    state_nx = S_MEAS;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Result registers and handshake outputs. Results change only together
    // with an ack and hold until the next one.
    // ------------------------------------------------------------------
    always_ff @(posedge I_Clk) begin
        if (I_rst) begin
            O_app_ack     <= 1'b0;
            O_app_us      <= 32'd0;
            O_app_clk     <= 8'd0;
            O_app_timeout <= 1'b0;
        end else begin
            O_app_ack <= finish;
            if (finish) begin
                if (finish_to) begin
                    O_app_us      <= TIMEOUT_US;
                    O_app_clk     <= 8'd0;
                    O_app_timeout <= 1'b1;
                end else begin
                    O_app_us      <= us_cnt;
                    O_app_clk     <= clk_cnt;
                    O_app_timeout <= 1'b0;
                end
            end
        end
    end

    // Registered decode, so busy follows the state one cycle late.
    always_ff @(posedge I_Clk) begin
        if (I_rst) begin
            O_app_busy <= 1'b0;
        end else begin
            O_app_busy <= (state == S_ARM) || (state == S_MEAS);
        end
    end

endmodule
